// File: rtl/tick_generator.sv
// ---------------------------------------------------------------------------
// tick_generator
//
// Multi-channel clock-enable generator. Each channel divides the system clock
// by (max_i + 1) and produces a one-cycle tick plus a 50%-duty square wave.
// Outputs are enables for downstream logic, never used as clocks.
//
// Ports
//   clk    in   system clock, all logic on the rising edge
//   rst    in   synchronous active-high reset (all channels)
//   en     in   [CHANNELS]        per-channel count enable
//   max    in   [CHANNELS*WIDTH]  per-channel terminal count, channel i in
//                                 bits [i*WIDTH +: WIDTH]; period = max+1
//   sync   in   synchronous restart of all channels (keeps them phase-aligned)
//   tick   out  [CHANNELS]        registered one-cycle pulse per period
//   sq     out  [CHANNELS]        registered square wave, toggles per tick
//   phase  out  [CHANNELS*WIDTH]  current counter value, same packing as max
//
// There is no handshake on this block: inputs are sampled every edge and
// outputs are level/pulse signals valid for the cycle after each edge.
// ---------------------------------------------------------------------------
module tick_generator #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] max,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       sq,
    output logic [CHANNELS*WIDTH-1:0] phase
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] max_i;
        logic             at_term;

        assign max_i = max[i*WIDTH +: WIDTH];

        // Unsigned >= rather than ==: lowering max below the running count
        // restarts the channel on the next enabled edge instead of letting
        // the counter run all the way around 2^WIDTH.
        assign at_term = (cnt >= max_i);

        always_ff @(posedge clk) begin
            if (rst || sync) begin
                cnt     <= '0;
                tick[i] <= 1'b0;
                sq[i]   <= 1'b0;
            end else if (!en[i]) begin
                // Count and square wave hold; a pending tick is deferred to
                // the first enabled edge because at_term is still true then.
                tick[i] <= 1'b0;
            end else if (at_term) begin
                cnt     <= '0;
                tick[i] <= 1'b1;
                sq[i]   <= ~sq[i];
            end else begin
                cnt     <= cnt + 1'b1;
                tick[i] <= 1'b0;
            end
        end

        assign phase[i*WIDTH +: WIDTH] = cnt;
    end

endmodule

// File: doc/tick_generator.md
# tick_generator

Parametrised multi-channel clock-enable generator for the watch and display datapaths. Each channel divides the single system clock by a runtime-programmable value and produces a one-cycle tick (clock enable) and a 50%-duty square wave. All channels can be restarted together so they stay phase-aligned. The block is driven from the system clock and feeds seconds, fast-set and display-scan timing to downstream logic as enables, never as derived clocks.

## Interface
- WIDTH, 32: counter and divide-value width per channel.
- CHANNELS, 3: number of independent divider channels.
- clk  in  1  system clock (50 MHz); all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  CHANNELS  per-channel count enable.
- max  in  CHANNELS*WIDTH  per-channel terminal count, channel i in bits [i*WIDTH +: WIDTH]; period = max+1 cycles.
- sync  in  1  synchronous restart of all channels.
- tick  out  CHANNELS  registered one-cycle pulse per period.
- sq  out  CHANNELS  registered square wave, toggles on each tick; period 2*(max+1).
- phase  out  CHANNELS*WIDTH  current counter value per channel, same packing as max.

## Operation
- Per channel i: WIDTH-bit counter cnt_i, registers tick_i, sq_i. phase_i = cnt_i.
- Priority per edge: rst > sync > en_i low > count.
- rst or sync: cnt_i <= 0, tick_i <= 0, sq_i <= 0 for all channels.
- en_i = 0: cnt_i and sq_i hold, tick_i <= 0.
- en_i = 1 and cnt_i >= max_i: tick_i <= 1, cnt_i <= 0, sq_i <= ~sq_i.
- en_i = 1 and cnt_i < max_i: tick_i <= 0, cnt_i <= cnt_i + 1.
- Comparison is >= (unsigned), not ==: if max_i is lowered below the current count, the channel ticks on the next enabled edge and restarts; no counter runaway through 2^WIDTH.
- max_i raised mid-period: counting continues to the new value, no extra tick.
- max_i = 0: tick_i high on every enabled cycle, sq_i toggles every cycle (clk/2).
- max_i = 2^WIDTH-1: counter reaches all-ones and wraps to 0 with a tick; no overflow path.
- Channels are fully independent except for shared rst/sync.

## Timing
- Reset values: tick = 0, sq = 0, phase = 0 on all channels.
- Edge k = k-th rising edge after rst/sync deasserts, en_i steady high, max_i = M: phase_i = k for k <= M; at edge M+1 tick_i rises, phase_i = 0, sq_i = 1.
- tick_i high exactly one cycle; subsequent ticks at edges n*(M+1), n >= 1.
- sq_i high for M+1 cycles, low for M+1 cycles.
- en_i dropped then restored: count resumes from held value; period stretched by cycles disabled; no tick lost or duplicated.
- en_i low during the cycle a tick would have been generated: tick deferred to the first enabled edge.
- sync asserted mid-period: takes effect at that edge; tick in flight is cleared (tick 0 after the sync edge).
- rst mid-operation identical to sync plus any future state.
- Latency from max_i change to effect: one edge (compared combinationally against registered cnt).

## Test plan
- rst high 3 cycles, release with en=1, max0=4: tick0 high after edges 5, 10, 15; sq0 = 1 after edge 5, 0 after edge 10; phase0 cycles 1,2,3,4,0.
- max1=0, en1=1: tick1 constantly 1 after edge 1, sq1 toggles every cycle; max2=2 concurrently gives tick2 at edges 3, 6, 9.
- max0=9, run to phase0=7, set max0=3: tick0 at next edge, phase0 = 0, then period 4.
- max0=4, drop en0 at phase0=2 for 6 cycles: phase0 holds 2, tick0 stays 0; after restore tick0 at third enabled edge.
- Three channels max=4,6,10 running freely, assert sync one cycle: all phase = 0, tick = 0, sq = 0; channels then tick at edges 5, 7, 11 after sync.
- WIDTH=4, max0=15: phase0 reaches 15, tick0 fires, phase0 wraps to 0, period 16, no spurious tick.
